// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command decoder: run/stop and clear pulses, decimal counter report
module uart_cmd_ctrl #(
    parameter logic [13:0] MAX_VAL = 14'd9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_done,
    input  logic [13:0] i_digit,
    input  logic        i_tx_done,
    output logic        o_run_stop,
    output logic        o_clear,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] WAIT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] bin_q, bin_d;
    logic [3:0]  iter_q, iter_d;
    logic [2:0]  idx_q, idx_d;
    logic        run_stop_q, run_stop_d;
    logic        clear_q, clear_d;

    logic        is_run, is_clr, is_snd, accept_s;
    logic [14:0] bcd_adj;
    logic [2:0]  top_adj;
    logic [7:0]  tx_byte;

    assign is_run   = (i_rx_data == 8'h52) || (i_rx_data == 8'h72);
    assign is_clr   = (i_rx_data == 8'h43) || (i_rx_data == 8'h63);
    assign is_snd   = (i_rx_data == 8'h53) || (i_rx_data == 8'h73);
    assign accept_s = i_rx_done && is_snd && (state_q == IDLE);

    // Bit 15 of the adjusted BCD is shifted out, so only the low 3 bits of the top nibble matter.
    always_comb begin
        bcd_adj = 15'd0;
        for (int n = 0; n < 3; n++) begin
            bcd_adj[4*n +: 4] = (bcd_q[4*n +: 4] >= 4'd5) ? bcd_q[4*n +: 4] + 4'd3 : bcd_q[4*n +: 4];
        end
        top_adj = (bcd_q[15:12] >= 4'd5) ? bcd_q[14:12] + 3'd3 : bcd_q[14:12];
        bcd_adj[14:12] = top_adj;
    end

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        iter_d     = iter_q;
        idx_d      = idx_q;
        run_stop_d = i_rx_done && is_run;
        clear_d    = i_rx_done && is_clr;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    bin_d   = (i_digit > MAX_VAL) ? MAX_VAL : i_digit;
                    bcd_d   = 16'd0;
                    iter_d  = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = {bcd_adj, bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == 3'd5) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            3'd0:    tx_byte = {4'h3, bcd_q[15:12]};
            3'd1:    tx_byte = {4'h3, bcd_q[11:8]};
            3'd2:    tx_byte = {4'h3, bcd_q[7:4]};
            3'd3:    tx_byte = {4'h3, bcd_q[3:0]};
            3'd4:    tx_byte = 8'h0D;
            3'd5:    tx_byte = 8'h0A;
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bcd_q      <= 16'd0;
            bin_q      <= 14'd0;
            iter_q     <= 4'd0;
            idx_q      <= 3'd0;
            run_stop_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            iter_q     <= iter_d;
            idx_q      <= idx_d;
            run_stop_q <= run_stop_d;
            clear_q    <= clear_d;
        end
    end

    assign o_run_stop = run_stop_q;
    assign o_clear    = clear_q;
    assign o_tx_start = (state_q == SEND);
    assign o_busy     = (state_q != IDLE);
    // Data is only driven while a byte is in flight; idx and BCD are frozen then.
    assign o_tx_data  = ((state_q == SEND) || (state_q == WAIT)) ? tx_byte : 8'h00;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_done = 1'b0;
    logic [13:0] i_digit = 14'd0;
    logic        i_tx_done = 1'b0;
    logic        o_run_stop, o_clear, o_tx_start, o_busy;
    logic [7:0]  o_tx_data;

    int errors = 0;
    int checks = 0;

    uart_cmd_ctrl #(.MAX_VAL(14'd9999)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_digit    (i_digit),
        .i_tx_done  (i_tx_done),
        .o_run_stop (o_run_stop),
        .o_clear    (o_clear),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic report(input string tag, input logic [13:0] val, input logic [47:0] exp,
                          input bit disturb);
        int  k;
        bit  seen;
        i_digit   = val;
        i_rx_data = 8'h53;
        i_rx_done = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            i_rx_done = 1'b0;
            i_tx_done = 1'b0;
            if (k == 1) check({tag, " busy after accept"}, o_busy, 1);
            if (disturb) begin
                case (k)
                    3: i_digit = 14'd42;
                    4: begin i_rx_data = 8'h53; i_rx_done = 1'b1; end
                    6: i_tx_done = 1'b1;
                    8: begin i_rx_data = 8'h52; i_rx_done = 1'b1; end
                    9: check({tag, " run_stop while busy"}, o_run_stop, 1);
                    10: check({tag, " run_stop one cycle"}, o_run_stop, 0);
                    default: ;
                endcase
            end
            seen = o_tx_start;
        end
        check({tag, " first start latency"}, k, 15);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s byte%0d", tag, i), o_tx_data, exp[47-8*i -: 8]);
            @(negedge clk);
            check($sformatf("%s byte%0d single start", tag, i), o_tx_start, 0);
            repeat (8) @(negedge clk);
            check($sformatf("%s byte%0d hold", tag, i), o_tx_data, exp[47-8*i -: 8]);
            i_tx_done = 1'b1;
            @(negedge clk);
            i_tx_done = 1'b0;
            if (i < 5) check($sformatf("%s byte%0d next start", tag, i), o_tx_start, 1);
            else       check({tag, " busy drop"}, o_busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int starts;
        int cd;
        int k;
        logic [7:0] junk [3];

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", o_busy, 0);
        check("rst start", o_tx_start, 0);
        check("rst run_stop", o_run_stop, 0);
        check("rst clear", o_clear, 0);
        check("rst tx_data", o_tx_data, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Run/stop then clear
        i_rx_data = 8'h52; i_rx_done = 1'b1;
        @(negedge clk); i_rx_done = 1'b0;
        check("R run_stop", o_run_stop, 1);
        check("R clear", o_clear, 0);
        check("R start", o_tx_start, 0);
        @(negedge clk);
        check("R run_stop width", o_run_stop, 0);
        i_rx_data = 8'h63; i_rx_done = 1'b1;
        @(negedge clk); i_rx_done = 1'b0;
        check("c clear", o_clear, 1);
        check("c run_stop", o_run_stop, 0);
        @(negedge clk);
        check("c clear width", o_clear, 0);
        check("c start", o_tx_start, 0);

        report("r1234", 14'd1234,  {"1234", 8'h0D, 8'h0A}, 1'b0);
        report("r0",    14'd0,     {"0000", 8'h0D, 8'h0A}, 1'b0);
        report("r9999", 14'd9999,  {"9999", 8'h0D, 8'h0A}, 1'b0);
        report("rsat",  14'd16383, {"9999", 8'h0D, 8'h0A}, 1'b0);
        report("snap",  14'd567,   {"0567", 8'h0D, 8'h0A}, 1'b1);
        @(negedge clk);
        check("snap idle after", o_busy, 0);

        // Reset while waiting on byte 2
        i_digit = 14'd3210;
        i_rx_data = 8'h73; i_rx_done = 1'b1;
        starts = 0; cd = 0; k = 0;
        while (starts < 3 && k < 200) begin
            @(negedge clk);
            k++;
            i_rx_done = 1'b0;
            i_tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) i_tx_done = 1'b1;
            end
            if (o_tx_start) begin
                starts++;
                if (starts < 3) cd = 3;
            end
        end
        check("mid starts reached", starts, 3);
        check("mid byte2", o_tx_data, 8'h31);
        repeat (2) @(negedge clk);
        check("mid in wait", o_busy, 1);
        reset = 1'b1;
        #1;
        check("mid rst busy", o_busy, 0);
        check("mid rst start", o_tx_start, 0);
        check("mid rst tx_data", o_tx_data, 8'h00);
        check("mid rst pulses", {o_run_stop, o_clear}, 0);
        @(negedge clk);
        reset = 1'b0;
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        check("mid stray done idle", {o_busy, o_tx_start}, 0);
        report("after", 14'd3210, {"3210", 8'h0D, 8'h0A}, 1'b0);

        // Junk bytes
        junk[0] = 8'h41; junk[1] = 8'h00; junk[2] = 8'hFF;
        for (int j = 0; j < 3; j++) begin
            i_rx_data = junk[j]; i_rx_done = 1'b1;
            @(negedge clk); i_rx_done = 1'b0;
            for (int c = 0; c < 3; c++) begin
                check($sformatf("junk%0d quiet", j), {o_run_stop, o_clear, o_busy, o_tx_start}, 0);
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

- **Role:** interprets ASCII command bytes from the UART receiver and drives the stopwatch control path.
- **Commands:** it issues single-cycle run/stop and clear pulses to the button FSM, and on request reports the current counter value back over the UART transmitter as four decimal ASCII digits plus CR LF.
- **Position:** it sits between the `uart` rx outputs and the `fsm_btn` inputs. Its transmit handshake replaces the rx-echo connection at the `uart` tx input.

## Interface
Parameters:
- `MAX_VAL`, default 9999: saturation limit applied to the `i_digit` snapshot.

Ports:
- `clk`, in, 1: system clock. The block has one clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_rx_data`, in, 8: received byte. Valid only in cycles where `i_rx_done` = 1.
- `i_rx_done`, in, 1: one-cycle strobe for a received byte.
- `i_digit`, in, 14: live upcounter value.
- `i_tx_done`, in, 1: one-cycle strobe from the transmitter marking the end of a byte.
- `o_run_stop`, out, 1: one-cycle pulse, equivalent to a debounced btnr press.
- `o_clear`, out, 1: one-cycle pulse, equivalent to a debounced btnu press.
- `o_tx_start`, out, 1: one-cycle request to transmit `o_tx_data`.
- `o_tx_data`, out, 8: byte to transmit. Held stable from `o_tx_start` until `i_tx_done`.
- `o_busy`, out, 1: high whenever a report is in progress (FSM state ≠ IDLE).

## Operation
Command decode runs every cycle with `i_rx_done` = 1, independent of the report FSM:
- `'R'` (0x52) or `'r'` (0x72): `o_run_stop` = 1 in the next cycle.
- `'C'` (0x43) or `'c'` (0x63): `o_clear` = 1 in the next cycle.
- `'S'` (0x53) or `'s'` (0x73): starts a report if the FSM is in IDLE. It is ignored if `o_busy` = 1.
- Any other byte is ignored with no output change.

Report FSM states: IDLE, CONV, SEND, WAIT.
- **IDLE:** on an accepted `'S'`, snapshot min(`i_digit`, `MAX_VAL`) and clear the 16-bit BCD register and the 4-bit iteration counter. Go to CONV.
- **CONV:** double-dabble binary-to-BCD, one iteration per clock, 14 iterations.
  - Each iteration adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by 1.
  - After the 14th iteration, set byte index = 0 and go to SEND.
- **SEND:** `o_tx_start` = 1 for exactly this one cycle. `o_tx_data` = byte[index]. Go to WAIT.
- **WAIT:** hold `o_tx_data`.
  - On `i_tx_done` with index < 5: index++, go to SEND.
  - On `i_tx_done` with index = 5: go to IDLE.
- **Byte sequence:** index 0..3 = 0x30 + BCD thousands, hundreds, tens, ones (leading zeros sent). Index 4 = 0x0D. Index 5 = 0x0A.
- **Stray strobes:** `i_tx_done` outside WAIT is ignored.
- **Snapshot:** the value is frozen at acceptance. Counter changes during the report do not alter the transmitted value.
- **R/C during a report:** an `'R'` or `'C'` received while busy still pulses its output and does not disturb the report.

## Timing
- **Reset values:** assertion of `reset` at any time forces the following asynchronously:
  - FSM state to IDLE.
  - `o_run_stop`, `o_clear`, `o_tx_start` and `o_busy` to 0.
  - `o_tx_data` to 0x00.
  - Counters and BCD register to 0.
  - A report in progress is abandoned and not resumed.
- **Command latency:** `o_run_stop`/`o_clear` are registered. They are high in the cycle after the `i_rx_done` edge, for exactly 1 cycle.
- **Report latency:** the first `o_tx_start` is high in the cycle after the 15th clock edge following the accepting edge (the accept edge, then 14 CONV edges).
- **Next-byte latency:** `o_tx_start` for the next byte is high in the cycle immediately after the `i_tx_done` edge. `o_tx_start` is never high in two consecutive cycles.
- **Return to idle:** `o_busy` falls in the cycle after the `i_tx_done` of byte 5. A new `'S'` is accepted in that cycle or later.
- **Simultaneous events:** `i_tx_done` and `i_rx_done` in the same cycle are both honoured. If the byte is `'S'`, it is ignored unless the FSM is in IDLE at that edge.

## Test plan
- **Run/stop and clear:** reset, then rx `'R'`, then rx `'c'` → one `o_run_stop` pulse, then one `o_clear` pulse, each 1 cycle wide and 1 cycle after its `i_rx_done`. `o_tx_start` stays 0.
- **Basic report:** `i_digit` = 1234, rx `'S'`, tx model returns `i_tx_done` 10 cycles after each start → bytes 0x31 0x32 0x33 0x34 0x0D 0x0A. The first start is 15 edges after accept. `o_busy` drops after the 6th done.
- **Boundary values:** `i_digit` = 0 → "0000"\r\n. `i_digit` = 9999 → "9999"\r\n. `i_digit` = 16383 → "9999"\r\n (saturated).
- **Snapshot and busy behaviour:** during a report, change `i_digit` to 42, send rx `'S'` and `'R'`, and inject a stray `i_tx_done` while in CONV → the original digits are sent, the second `'S'` is ignored, `o_run_stop` pulses, and no byte is skipped.
- **Reset mid-report:** assert `reset` while in WAIT at byte 2 → all outputs go to 0 immediately. A subsequent `'S'` produces a complete 6-byte report from byte 0.
- **Junk bytes:** rx 0x41, 0x00 and 0xFF → no output activity, FSM stays in IDLE.
